// File: rtl/mwas_pkg.sv
// Shared types and constants for the sequenced multi-word adder/subtractor.
package mwas_pkg;

    localparam int SLICE_W   = 16;
    localparam int MAX_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for a word counter; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        for (w = 1; (1 << w) < value; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/addsub_slice_16b.sv
// Combinational 16-bit add/sub slice, carry-lookahead over four 4-bit groups.
// Also exports the carry into bit 15 so the caller can form signed overflow.
module addsub_slice_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        inv,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        c15
);

    logic [15:0] bx_s;
    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [15:0] c_s;
    logic [3:0]  gg_s;
    logic [3:0]  gp_s;
    logic [4:0]  gc_s;

    // Bit and group generate/propagate terms.
    always_comb begin
        bx_s = b ^ {16{inv}};
        g_s  = a & bx_s;
        p_s  = a ^ bx_s;
        gg_s = 4'd0;
        gp_s = 4'd0;
        for (int k = 0; k < 4; k++) begin
            gg_s[k] = g_s[4*k+3]
                    | (p_s[4*k+3] & g_s[4*k+2])
                    | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            gp_s[k] = &p_s[4*k +: 4];
        end
    end

    // Group-level lookahead carries.
    always_comb begin
        gc_s[0] = cin;
        gc_s[1] = gg_s[0] | (gp_s[0] & cin);
        gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
        gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
        gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                | (&gp_s & cin);
    end

    // Bit carries inside each group from that group's carry-in.
    always_comb begin
        c_s = 16'd0;
        for (int k = 0; k < 4; k++) begin
            c_s[4*k]   = gc_s[k];
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
        end
    end

    assign sum  = p_s ^ c_s;
    assign cout = gc_s[4];
    assign c15  = c_s[15];

endmodule

// File: rtl/multiword_addsub_sequencer.sv
// Multi-precision add/sub reusing one 16-bit slice per word, LS word first.
// Define MWAS_FLAGS_EN to add registered zero/neg/ovf result flags.
module multiword_addsub_sequencer
    import mwas_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    input  logic                       s,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       cout
`ifdef MWAS_FLAGS_EN
    ,
    output logic                       zero,
    output logic                       neg,
    output logic                       ovf
`endif
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = clog2(WORDS);

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               s_r;
    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               last_word_s;
    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic [SLICE_W-1:0] slice_sum_s;
    logic               slice_cout_s;
    logic               slice_c15_s;
    logic [W-1:0]       sum_next_s;
`ifdef MWAS_FLAGS_EN
    logic               zero_r;
    logic               neg_r;
    logic               ovf_r;
`endif

    addsub_slice_16b u_slice (
        .a    (slice_a_s),
        .b    (slice_b_s),
        .inv  (s_r),
        .cin  (carry_r),
        .sum  (slice_sum_s),
        .cout (slice_cout_s),
        .c15  (slice_c15_s)
    );

    // Select the current word and merge the slice result into the result image.
    always_comb begin
        last_word_s = (idx_r == IDX_W'(WORDS - 1));
        slice_a_s   = a_r[SLICE_W*idx_r +: SLICE_W];
        slice_b_s   = b_r[SLICE_W*idx_r +: SLICE_W];
        sum_next_s  = sum_r;
        sum_next_s[SLICE_W*idx_r +: SLICE_W] = slice_sum_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = RUN;
                else          state_next_s = IDLE;
            end
            RUN: begin
                if (last_word_s) state_next_s = DONE;
                else             state_next_s = RUN;
            end
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, operand, carry and result registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            carry_r     <= 1'b0;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            s_r         <= 1'b0;
            sum_r       <= {W{1'b0}};
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef MWAS_FLAGS_EN
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        s_r     <= s;
                        idx_r   <= {IDX_W{1'b0}};
                        carry_r <= s;
                    end
                end
                RUN: begin
                    sum_r   <= sum_next_s;
                    carry_r <= slice_cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_word_s) begin
                        cout_r <= slice_cout_s;
`ifdef MWAS_FLAGS_EN
                        zero_r <= (sum_next_s == {W{1'b0}});
                        neg_r  <= slice_sum_s[SLICE_W-1];
                        ovf_r  <= slice_cout_s ^ slice_c15_s;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
`ifdef MWAS_FLAGS_EN
    assign zero      = zero_r;
    assign neg       = neg_r;
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Directed bench for multiword_addsub_sequencer with WORDS=4 (64-bit operands).
module tb_multiword_addsub_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef MWAS_FLAGS_EN
    logic         zero;
    logic         neg;
    logic         ovf;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    multiword_addsub_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef MWAS_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request, let it be accepted, then scramble the inputs.
    task automatic start_op(input logic [63:0] a_v, input logic [63:0] b_v, input logic s_v);
        @(negedge clk);
        a        = a_v;
        b        = b_v;
        s        = s_v;
        in_valid = 1'b1;
        check_val("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 64'hA5A5_5A5A_C3C3_3C3C;
        b        = 64'h1234_4321_F0F0_0F0F;
        s        = ~s_v;
    endtask

    // Edges from the accepting edge (counted as 1) until out_valid is seen.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_val("latency", 64'(edges), 64'd5);
    endtask

    task automatic check_result(input logic [63:0] a_v, input logic [63:0] b_v, input logic s_v,
                                input logic [63:0] exp_sum, input logic exp_cout);
        logic [63:0] bx;
        bx = s_v ? ~b_v : b_v;
        check_val("out_valid", {63'd0, out_valid}, 64'd1);
        check_val("sum", sum, exp_sum);
        check_val("cout", {63'd0, cout}, {63'd0, exp_cout});
`ifdef MWAS_FLAGS_EN
        check_val("zero", {63'd0, zero}, {63'd0, (exp_sum == 64'd0)});
        check_val("neg", {63'd0, neg}, {63'd0, exp_sum[63]});
        check_val("ovf", {63'd0, ovf},
                  {63'd0, ((a_v[63] == bx[63]) && (exp_sum[63] != a_v[63]))});
`else
        if (bx === 64'hx) $display("note: unknown operand");
`endif
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("out_valid_drop", {63'd0, out_valid}, 64'd0);
        check_val("in_ready_back", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic do_op(input logic [63:0] a_v, input logic [63:0] b_v, input logic s_v,
                         input logic [63:0] exp_sum, input logic exp_cout);
        int edges;
        start_op(a_v, b_v, s_v);
        wait_done(edges);
        check_result(a_v, b_v, s_v, exp_sum, exp_cout);
        release_result();
    endtask

    initial begin
        int edges;
        logic [63:0] held_sum;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 64'd0;
        b         = 64'd0;
        s         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_sum", sum, 64'd0);
        check_val("rst_cout", {63'd0, cout}, 64'd0);
        rst_n = 1'b1;

        // Carry from word 0 into word 1.
        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
        // Borrow across all words, then a small in-range subtract.
        do_op(64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_op(64'h5, 64'h3, 1'b1, 64'h2, 1'b1);
        // Full ripple to zero with carry out.
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
        // Mixed words, no inter-word carry.
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0);
        // Equal operands subtract to zero, no borrow.
        do_op(64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h0, 1'b1);
        // Signed overflow on subtract.
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

        // Backpressure: result held while a new request waits.
        start_op(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0);
        wait_done(edges);
        check_result(64'h3, 64'h4, 1'b0, 64'h7, 1'b0);
        held_sum = 64'h7;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 64'h0000_0001_0000_0000;
            b        = 64'hFFFF_FFFF_FFFF_FFFF;
            s        = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_val("bp_sum", sum, held_sum);
            check_val("bp_cout", {63'd0, cout}, 64'd0);
            check_val("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check_val("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("bp_idle_ready", {63'd0, in_ready}, 64'd1);
        check_val("bp_idle_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(edges);
        check_result(64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                     64'h0000_0000_FFFF_FFFF, 1'b1);
        release_result();

        // Reset in the middle of RUN at word index 2.
        start_op(64'h0003_0002_0001_0009, 64'h0001_0001_0001_0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("mid_rst_sum", sum, 64'd0);
        check_val("mid_rst_cout", {63'd0, cout}, 64'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_val("mid_rst_stays_idle", {63'd0, out_valid}, 64'd0);
        end
        do_op(64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 64'h0100_0100_0100_0100, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
